local_history_predictor: RTL and testbench

//  Alpha-21264-style local branch predictor feeding LPresult into the global/choice predictor stage.
//  Two-level structure: 1024x10b local history table (LHT) indexed by PC, 1024x3b saturating counter table (LPT) indexed by the history.

---
 rtl/lp_pkg.sv | 15 +
 rtl/lp_sat_counter.sv | 17 +
 rtl/local_history_predictor.sv | 113 +++++++++++
 tb/tb_local_history_predictor.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/lp_pkg.sv
// Shared types and default sizes for the local branch predictor and its helpers.
package lp_pkg;
    localparam int PC_BITS          = 10;
    localparam int LHIST_BITS       = 10;
    localparam int CTR_BITS         = 3;
    localparam int CTR_TAKEN_THRESH = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        PREDICT,
        WAIT,
        UPDATE
    } lp_state_e;
endpackage

// File: rtl/lp_sat_counter.sv
// Combinational W-bit saturating up/down counter step; shared with the choice stage.
module lp_sat_counter #(
    parameter int W = 3
) (
    input  logic [W-1:0] i_ctr,
    input  logic         i_inc,
    output logic [W-1:0] o_ctr
);
    always_comb begin
        o_ctr = i_ctr;
        if (i_inc) begin
            if (i_ctr != {W{1'b1}}) o_ctr = i_ctr + 1'b1;
        end else begin
            if (i_ctr != '0) o_ctr = i_ctr - 1'b1;
        end
    end
endmodule

// File: rtl/local_history_predictor.sv
// Two-level local branch predictor (per-PC history -> saturating counter), one branch in flight.
// Optional statistics counters are built when LOCAL_PRED_STATS_EN is defined.
module local_history_predictor
    import lp_pkg::*;
#(
    parameter int PC_BITS    = lp_pkg::PC_BITS,
    parameter int LHIST_BITS = lp_pkg::LHIST_BITS,
    parameter int CTR_BITS   = lp_pkg::CTR_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  BranchValid,
    input  logic [PC_BITS-1:0]    PCindex,
    output logic                  Ready,
    output logic                  LPresult,
    output logic                  LPvalid,
    input  logic                  ResolveValid,
    input  logic                  BranchTaken,
    output logic [LHIST_BITS-1:0] LHresult
`ifdef LOCAL_PRED_STATS_EN
    ,
    output logic [15:0]           BranchCount,
    output logic [15:0]           MispredictCount
`endif
);
    localparam int LHT_DEPTH = 2 ** PC_BITS;
    localparam int LPT_DEPTH = 2 ** LHIST_BITS;

    lp_state_e r_state, w_next;

    logic [LHIST_BITS-1:0] r_lht [LHT_DEPTH];
    logic [CTR_BITS-1:0]   r_lpt [LPT_DEPTH];
    logic [PC_BITS-1:0]    r_idx;
    logic [LHIST_BITS-1:0] r_lhr;
    logic [CTR_BITS-1:0]   r_ctr;
    logic                  r_lp;
    logic                  r_taken;
    logic [CTR_BITS-1:0]   w_ctr_nxt;

    lp_sat_counter #(.W(CTR_BITS)) u_sat (
        .i_ctr (r_ctr),
        .i_inc (r_taken),
        .o_ctr (w_ctr_nxt)
    );

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (BranchValid) w_next = LOOKUP;
            LOOKUP:  w_next = PREDICT;
            PREDICT: w_next = WAIT;
            WAIT:    if (ResolveValid) w_next = UPDATE;
            UPDATE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Reset clears both tables so a reset mid-flight leaves no partial training behind.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LHT_DEPTH; i++) r_lht[i] <= '0;
            for (int i = 0; i < LPT_DEPTH; i++) r_lpt[i] <= '0;
            r_idx   <= '0;
            r_lhr   <= '0;
            r_ctr   <= '0;
            r_lp    <= 1'b0;
            r_taken <= 1'b0;
        end else begin
            case (r_state)
                IDLE:    if (BranchValid) r_idx <= PCindex;
                LOOKUP:  r_lhr <= r_lht[r_idx];
                PREDICT: begin
                    r_ctr <= r_lpt[r_lhr];
                    r_lp  <= r_lpt[r_lhr][CTR_BITS-1];
                end
                WAIT:    if (ResolveValid) r_taken <= BranchTaken;
                UPDATE:  begin
                    r_lpt[r_lhr] <= w_ctr_nxt;
                    r_lht[r_idx] <= {r_lhr[LHIST_BITS-2:0], r_taken};
                end
                default: ;
            endcase
        end
    end

`ifdef LOCAL_PRED_STATS_EN
    logic [15:0] r_branch_cnt;
    logic [15:0] r_mispred_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (r_state == UPDATE) begin
            r_branch_cnt <= r_branch_cnt + 16'd1;
            if (r_lp != r_taken) r_mispred_cnt <= r_mispred_cnt + 16'd1;
        end
    end

    assign BranchCount     = r_branch_cnt;
    assign MispredictCount = r_mispred_cnt;
`endif

    assign Ready    = (r_state == IDLE);
    assign LPvalid  = (r_state == WAIT);
    assign LPresult = r_lp;
    assign LHresult = r_lhr;
endmodule

// File: tb/tb_local_history_predictor.sv
// Scoreboard bench: lookups queue the expected {prediction, history}; a monitor checks on LPvalid.
module tb_local_history_predictor;
    logic       clock = 1'b0;
    logic       reset;
    logic       BranchValid;
    logic [9:0] PCindex;
    logic       Ready;
    logic       LPresult;
    logic       LPvalid;
    logic       ResolveValid;
    logic       BranchTaken;
    logic [9:0] LHresult;
`ifdef LOCAL_PRED_STATS_EN
    logic [15:0] BranchCount;
    logic [15:0] MispredictCount;
`endif

    local_history_predictor dut (
        .clock        (clock),
        .reset        (reset),
        .BranchValid  (BranchValid),
        .PCindex      (PCindex),
        .Ready        (Ready),
        .LPresult     (LPresult),
        .LPvalid      (LPvalid),
        .ResolveValid (ResolveValid),
        .BranchTaken  (BranchTaken),
        .LHresult     (LHresult)
`ifdef LOCAL_PRED_STATS_EN
        ,
        .BranchCount     (BranchCount),
        .MispredictCount (MispredictCount)
`endif
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;
    logic [10:0] exp_q[$];
    logic prev_v = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Monitor: each new WAIT entry presents one prediction to score.
    always @(negedge clock) begin
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            if (LPvalid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_lpvalid", 32'd1, 32'd0);
                end else begin
                    logic [10:0] e;
                    e = exp_q.pop_front();
                    chk("LPresult", {31'd0, LPresult}, {31'd0, e[10]});
                    chk("LHresult", {22'd0, LHresult}, {22'd0, e[9:0]});
                end
            end
            prev_v = LPvalid;
        end
    end

    task automatic lookup(input logic [9:0] pc, input logic exp_lp, input logic [9:0] exp_lh);
        int n;
        exp_q.push_back({exp_lp, exp_lh});
        @(negedge clock);
        BranchValid = 1'b1;
        PCindex     = pc;
        @(negedge clock);
        BranchValid = 1'b0;
        chk("ready_busy", {31'd0, Ready}, 32'd0);
        n = 1;
        while (!LPvalid && n < 10) begin
            @(negedge clock);
            n++;
        end
        chk("lookup_latency", n, 32'd3);
    endtask

    task automatic resolve(input logic t);
        @(negedge clock);
        ResolveValid = 1'b1;
        BranchTaken  = t;
        @(negedge clock);
        ResolveValid = 1'b0;
        chk("ready_update", {31'd0, Ready}, 32'd0);
        @(negedge clock);
        chk("ready_idle", {31'd0, Ready}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_ready",    {31'd0, Ready},    32'd1);
        chk("rst_lpvalid",  {31'd0, LPvalid},  32'd0);
        chk("rst_lpresult", {31'd0, LPresult}, 32'd0);
        chk("rst_lhresult", {22'd0, LHresult}, 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        BranchValid  = 1'b0;
        PCindex      = '0;
        ResolveValid = 1'b0;
        BranchTaken  = 1'b0;
        repeat (2) @(negedge clock);
        do_reset();

        // Train PC 5 taken: history fills to 3FF by the 11th lookup, counter reaches 4 on the 15th
        // and saturates at 7 afterwards.
        for (int k = 0; k <= 20; k++) begin
            lookup(10'd5, (k >= 14), (k >= 10) ? 10'h3FF : 10'((1 << k) - 1));
            resolve(1'b1);
        end

        // Reset while waiting for resolution: nothing is written back.
        lookup(10'd5, 1'b1, 10'h3FF);
        do_reset();
        lookup(10'd5, 1'b0, 10'h000);
        resolve(1'b0);

        // Not-taken from a zero counter must stay at zero.
        for (int k = 0; k < 3; k++) begin
            lookup(10'd9, 1'b0, 10'h000);
            resolve(1'b0);
        end

        // Stray request/resolve strobes outside their accepting states.
        exp_q.push_back({1'b0, 10'h000});
        @(negedge clock);
        BranchValid = 1'b1;
        PCindex     = 10'd20;
        @(negedge clock);
        PCindex = 10'd21;
        chk("ready_lookup", {31'd0, Ready}, 32'd0);
        @(negedge clock);
        BranchValid  = 1'b0;
        ResolveValid = 1'b1;
        BranchTaken  = 1'b1;
        @(negedge clock);
        ResolveValid = 1'b0;
        BranchValid  = 1'b1;
        chk("wait_lpvalid", {31'd0, LPvalid}, 32'd1);
        @(negedge clock);
        BranchValid = 1'b0;
        chk("wait_hold", {31'd0, LPvalid}, 32'd1);
        chk("wait_ready", {31'd0, Ready}, 32'd0);
        resolve(1'b0);
        @(negedge clock);
        ResolveValid = 1'b1;
        BranchTaken  = 1'b1;
        @(negedge clock);
        ResolveValid = 1'b0;
        chk("idle_resolve_ready", {31'd0, Ready}, 32'd1);
        chk("idle_resolve_lpvalid", {31'd0, LPvalid}, 32'd0);
        lookup(10'd20, 1'b0, 10'h000);
        resolve(1'b0);
        lookup(10'd21, 1'b0, 10'h000);
        resolve(1'b0);

        // Three resolutions from a clean reset, the first one mispredicted.
        do_reset();
        lookup(10'd30, 1'b0, 10'h000);
        resolve(1'b1);
        lookup(10'd30, 1'b0, 10'h001);
        resolve(1'b0);
        lookup(10'd30, 1'b0, 10'h002);
        resolve(1'b0);
`ifdef LOCAL_PRED_STATS_EN
        chk("branch_count",     {16'd0, BranchCount},     32'd3);
        chk("mispredict_count", {16'd0, MispredictCount}, 32'd1);
`endif

        repeat (2) @(negedge clock);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
